// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM encoding, bus-mode descriptor and default word width.
// Pure definitions, no timing or flow-control behaviour of its own.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer with 1-cycle rise/fall pulses on the synchronized level.
// Latency STAGES clk to the edge pulse; no backpressure, samples every cycle.
module spi_slave_sync #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] pipe;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= {STAGES{IDLE_VAL}};
      prev <= IDLE_VAL;
    end else begin
      pipe <= {pipe[STAGES-2:0], din};
      prev <= pipe[STAGES-1];
    end
  end

  assign rise = pipe[STAGES-1] & ~prev;
  assign fall = ~pipe[STAGES-1] & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder oversampled in the clk domain; rx_valid lands 1 clk after the synced final rise.
// No RX backpressure (consumer samples on rx_valid); TX words enter through the tx_ready/tx_load shadow.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t              state_q;
  state_t              state_d;
  logic                sclk_rise;
  logic                sclk_fall;
  logic                cs_rise;
  logic                cs_fall;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic                mosi_sync;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   rx_shift;
  logic [DATA_W-1:0]   rx_next;
  logic [DATA_W-1:0]   tx_shift;
  logic [DATA_W-1:0]   shadow;
  logic                shadow_full;
  logic                start;
  logic                active_rise;
  logic                active_fall;
  logic                word_load;
  logic                load_ok;

  spi_slave_sync #(
    .STAGES  (SYNC_STAGES),
    .IDLE_VAL(SPI_MODE0.cpol)
  ) u_sclk_sync (
    .clk (clk),
    .rst (rst),
    .din (sclk),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  spi_slave_sync #(
    .STAGES  (SYNC_STAGES),
    .IDLE_VAL(1'b1)
  ) u_cs_sync (
    .clk (clk),
    .rst (rst),
    .din (cs_n),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  // Same depth as the sclk path so mosi_sync is stable when the rise pulse appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_pipe <= '0;
    end else begin
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_sync = mosi_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_ACTIVE;
          start   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Deselect wins over a coincident sclk edge.
  assign active_rise = (state_q == ST_ACTIVE) && !cs_rise && sclk_rise;
  assign active_fall = (state_q == ST_ACTIVE) && !cs_rise && sclk_fall;
  assign word_load   = start || (active_fall && (bit_cnt == '0));
  assign load_ok     = tx_load && !shadow_full;
  assign rx_next     = {rx_shift[DATA_W-2:0], mosi_sync};

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= word_load && !shadow_full;

      if (start) begin
        bit_cnt <= '0;
      end else if (active_rise) begin
        rx_shift <= rx_next;
        bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        if (bit_cnt == LAST_BIT) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end
      end

      if (word_load) begin
        tx_shift <= shadow_full ? shadow : '0;
      end else if (active_fall) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end

      // A consume sees the pre-load state, so a same-cycle load waits for the next word.
      if (word_load && shadow_full) begin
        shadow_full <= 1'b0;
      end else if (load_ok) begin
        shadow_full <= 1'b1;
        shadow      <= tx_data;
      end
    end
  end

  assign busy     = (state_q == ST_ACTIVE);
  assign miso_oe  = busy;
  assign miso     = busy & tx_shift[DATA_W-1];
  assign tx_ready = !shadow_full;

endmodule

// File: tb/tb_spi_slave.sv
// Mode-0 SPI master model driving spi_slave with scoreboarded RX words and MISO words.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic       tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int rx_cnt   = 0;
  int und_cnt  = 0;

  logic [7:0] rx_exp_q[$];
  logic [7:0] miso_exp_q[$];
  logic [7:0] rx_e;

  always #5 clk = ~clk;

  spi_slave #(
    .DATA_W     (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .tx_underrun(tx_underrun),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy)
  );

  // RX scoreboard consumer and pulse counters.
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      rx_cnt++;
      checks++;
      if (rx_exp_q.size() == 0) begin
        failures++;
        $display("FAIL rx_unexpected: rx_valid with rx_data=%h, required no word", rx_data);
      end else begin
        rx_e = rx_exp_q.pop_front();
        if (rx_data !== rx_e) begin
          failures++;
          $display("FAIL rx_word: got %h, required %h", rx_data, rx_e);
        end
      end
    end
    if (!rst && tx_underrun) und_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_sel();
    cs_n = 1'b0;
    tick(4);
  endtask

  task automatic end_sel();
    tick(4);
    cs_n = 1'b1;
    tick(6);
  endtask

  task automatic load_word(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 50) begin
      tick(1);
      n++;
    end
    checks++;
    if (!tx_ready) begin
      failures++;
      $display("FAIL load_wait: tx_ready=%b after %0d cycles, required 1", tx_ready, n);
    end
    tx_data = d;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      tick(4);
      got[i] = miso;
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_word(input logic [7:0] b);
    logic [7:0] got;
    logic [7:0] e;
    rx_exp_q.push_back(b);
    spi_bits(b, 8, got);
    checks++;
    if (miso_exp_q.size() == 0) begin
      failures++;
      $display("FAIL miso_word: got %h, required no word queued", got);
    end else begin
      e = miso_exp_q.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL miso_word: got %h, required %h", got, e);
      end
    end
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    logic [13:0] exp_v;
    logic [7:0]  dummy;
    exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_load = 1'b0; tx_data = 8'h00;
    tick(3);
    obs = {miso, miso_oe, tx_ready, tx_underrun, rx_valid, busy, rx_data};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL reset_poweron: outputs %b, required %b", obs, exp_v);
    end
    rst = 1'b0;
    tick(2);
    load_word(8'h99);
    begin_sel();
    load_word(8'h77);
    spi_bits(8'hF0, 3, dummy);
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tick(3);
    obs = {miso, miso_oe, tx_ready, tx_underrun, rx_valid, busy, rx_data};
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL reset_midword: outputs %b, required %b", obs, exp_v);
    end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_single_word();
    int rx0;
    load_word(8'hA5);
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_loaded: tx_ready=%b, required 0", tx_ready);
    end
    rx0 = rx_cnt;
    begin_sel();
    checks++;
    if ({tx_ready, busy, miso_oe} !== 3'b111) begin
      failures++;
      $display("FAIL single_start: ready/busy/oe=%b, required 111", {tx_ready, busy, miso_oe});
    end
    miso_exp_q.push_back(8'hA5);
    spi_word(8'h3C);
    end_sel();
    checks++;
    if (rx_cnt - rx0 !== 1 || rx_data !== 8'h3C) begin
      failures++;
      $display("FAIL single_rx: pulses=%0d data=%h, required 1 and 3c", rx_cnt - rx0, rx_data);
    end
  endtask

  task automatic test_back_to_back();
    int rx0;
    rx0 = rx_cnt;
    load_word(8'h01);
    begin_sel();
    load_word(8'h02);
    miso_exp_q.push_back(8'h01);
    spi_word(8'h81);
    miso_exp_q.push_back(8'h02);
    spi_word(8'h7E);
    end_sel();
    checks++;
    if (rx_cnt - rx0 !== 2 || rx_data !== 8'h7E) begin
      failures++;
      $display("FAIL b2b_rx: pulses=%0d data=%h, required 2 and 7e", rx_cnt - rx0, rx_data);
    end
  endtask

  task automatic test_underrun();
    int u0;
    u0 = und_cnt;
    begin_sel();
    checks++;
    if (und_cnt - u0 !== 1) begin
      failures++;
      $display("FAIL underrun_pulse: got %0d pulses at word start, required 1", und_cnt - u0);
    end
    miso_exp_q.push_back(8'h00);
    spi_word(8'hFF);
    end_sel();
    checks++;
    if (rx_data !== 8'hFF) begin
      failures++;
      $display("FAIL underrun_rx: got %h, required ff", rx_data);
    end
  endtask

  task automatic test_abort();
    int         rx0;
    logic [7:0] dummy;
    rx0 = rx_cnt;
    begin_sel();
    load_word(8'hB7);
    spi_bits(8'hC3, 5, dummy);
    end_sel();
    checks++;
    if (rx_cnt !== rx0 || rx_data !== 8'hFF || busy !== 1'b0 || tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: pulses=%0d data=%h busy=%b ready=%b, required 0 ff 0 0",
               rx_cnt - rx0, rx_data, busy, tx_ready);
    end
    begin_sel();
    miso_exp_q.push_back(8'hB7);
    spi_word(8'h11);
    end_sel();
  endtask

  task automatic test_ignored_load();
    load_word(8'hAA);
    tx_data = 8'h55;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL ignored_ready: tx_ready=%b, required 0", tx_ready);
    end
    begin_sel();
    miso_exp_q.push_back(8'hAA);
    spi_word(8'h5A);
    end_sel();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_ignored_load();
    tick(4);
    checks++;
    if (rx_exp_q.size() != 0 || miso_exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: rx left=%0d miso left=%0d, required 0 and 0",
               rx_exp_q.size(), miso_exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
